aes128_key_sched: RTL and testbench

- Sequential AES-128 key-expansion stage for the aes128 datapath.
- Accepts a 128-bit cipher key and emits the 11 round keys (rounds 0..10), one per accepted handshake.
- Feeds the round-function/AddRoundKey logic directly downstream.
- Synthesises onto the same standard-cell library as the rest of the datapath.

---
 rtl/aes128_pkg.sv | 10 +
 rtl/aes128_sbox.sv | 25 ++
 rtl/aes128_key_sched.sv | 99 +++++++++
 tb/tb_aes128_key_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// aes128_pkg: shared AES-128 constants, key-schedule FSM state type and GF(2^8) xtime helper.
package aes128_pkg;
    localparam int ROUND_KEY_W = 128;
    localparam logic [7:0] AES_RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    typedef enum logic {IDLE, EMIT} state_e;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes128_sbox.sv
// aes128_sbox: combinational AES forward S-box, one byte in, one byte out.
module aes128_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign y = SBOX[a];
endmodule

// File: rtl/aes128_key_sched.sv
// aes128_key_sched: sequential AES-128 key expansion, one round key per rk_valid/rk_ready handshake.
// Optional AES128_KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes key material and returns to IDLE.
module aes128_key_sched
    import aes128_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic                   CLK,
    input  logic                   RSTB,
    input  logic [ROUND_KEY_W-1:0] key_in,
    input  logic                   key_load,
    input  logic                   rk_ready,
    output logic                   rk_valid,
    output logic [ROUND_KEY_W-1:0] round_key,
    output logic [IDX_W-1:0]       rk_index,
    output logic                   busy,
    output logic                   done
`ifdef AES128_KEY_SCHED_ZEROIZE_EN
    ,
    input  logic                   zeroize
`endif
);
    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes128_key_sched supports NUM_ROUNDS=10 only");
    end

    state_e                 state_q, state_d;
    logic [ROUND_KEY_W-1:0] key_q, key_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             rcon_q, rcon_d;
    logic                   done_q, done_d;
    logic [31:0]            rot, sub, t, w0, w1, w2, w3;

    // Next round key: SubWord(RotWord(w3)) mixed into the four words in a ripple
    assign rot = {key_q[23:0], key_q[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes128_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end
    assign t  = sub ^ {rcon_q, 24'h0};
    assign w0 = key_q[127:96] ^ t;
    assign w1 = key_q[95:64] ^ w0;
    assign w2 = key_q[63:32] ^ w1;
    assign w3 = key_q[31:0] ^ w2;

    assign rk_valid  = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign round_key = key_q;
    assign rk_index  = idx_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (key_load) begin
            state_d = EMIT;
            key_d   = key_in;
            idx_d   = '0;
            rcon_d  = AES_RCON[0];
        end else if (rk_valid && rk_ready) begin
            if (idx_q == IDX_W'(NUM_ROUNDS)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                key_d  = {w0, w1, w2, w3};
                idx_d  = idx_q + 1'b1;
                rcon_d = xtime(rcon_q);
            end
        end
`ifdef AES128_KEY_SCHED_ZEROIZE_EN
        if (zeroize) begin
            state_d = IDLE;
            key_d   = '0;
            idx_d   = '0;
            rcon_d  = AES_RCON[0];
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= AES_RCON[0];
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_aes128_key_sched.sv
// tb_aes128_key_sched: directed FIPS-197 vectors for the key schedule, checked with immediate assertions.
module tb_aes128_key_sched;
    logic         CLK = 1'b0;
    logic         RSTB;
    logic [127:0] key_in;
    logic         key_load;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;
`ifdef AES128_KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif
    int tests = 0;
    int fails = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] EXP [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes128_key_sched dut (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .key_in   (key_in),
        .key_load (key_load),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .round_key(round_key),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done)
`ifdef AES128_KEY_SCHED_ZEROIZE_EN
        ,
        .zeroize  (zeroize)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RSTB = 1'b0; key_in = '0; key_load = 1'b0; rk_ready = 1'b0;
`ifdef AES128_KEY_SCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        #12;
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_key", round_key, 0);
        check("rst_index", rk_index, 0);
        check("rst_done", done, 0);
        RSTB = 1'b1;
        tick();
        check("idle_valid", rk_valid, 0);

        // Full FIPS-197 schedule at one key per cycle
        key_in = FIPS_KEY; key_load = 1'b1;
        tick();
        key_load = 1'b0; rk_ready = 1'b1;
        check("load_valid", rk_valid, 1);
        check("load_busy", busy, 1);
        for (int r = 0; r <= 10; r++) begin
            check($sformatf("fips_idx%0d", r), rk_index, r);
            check($sformatf("fips_rk%0d", r), round_key, EXP[r]);
            check($sformatf("fips_nodone%0d", r), done, 0);
            if (r < 10) tick();
        end
        tick();
        check("end_done", done, 1);
        check("end_valid", rk_valid, 0);
        check("end_busy", busy, 0);
        check("end_keep_key", round_key, EXP[10]);
        tick();
        check("done_once", done, 0);

        // Backpressure at round 3
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        tick(); tick(); tick();
        check("bp_idx3", rk_index, 3);
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_hold_idx%0d", c), rk_index, 3);
            check($sformatf("bp_hold_rk%0d", c), round_key, EXP[3]);
            check($sformatf("bp_hold_valid%0d", c), rk_valid, 1);
        end
        rk_ready = 1'b1;
        tick();
        check("bp_resume_idx", rk_index, 4);
        check("bp_resume_rk", round_key, EXP[4]);

        // Restart with the all-zero key at round 6, colliding with a handshake
        tick(); tick();
        check("rs_idx6", rk_index, 6);
        key_in = '0; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("rs_idx0", rk_index, 0);
        check("rs_rk0", round_key, 0);
        check("rs_nodone0", done, 0);
        tick();
        check("rs_idx1", rk_index, 1);
        check("rs_rk1", round_key, ZERO_R1);
        check("rs_nodone1", done, 0);

        // Load in the cycle that would have raised done
        for (int c = 0; c < 9; c++) tick();
        check("ld_idx10", rk_index, 10);
        key_in = FIPS_KEY; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("ld_done_suppressed", done, 0);
        check("ld_valid", rk_valid, 1);
        check("ld_idx0", rk_index, 0);
        check("ld_rk0", round_key, FIPS_KEY);

        // Asynchronous reset mid-schedule, between clock edges
        tick();
        RSTB = 1'b0;
        #2;
        check("ar_valid", rk_valid, 0);
        check("ar_key", round_key, 0);
        check("ar_idx", rk_index, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        #2;
        RSTB = 1'b1;
        tick();
        check("ar_idle_valid", rk_valid, 0);
        check("ar_idle_busy", busy, 0);

`ifdef AES128_KEY_SCHED_ZEROIZE_EN
        key_in = FIPS_KEY; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        tick(); tick(); tick(); tick();
        check("zz_idx4", rk_index, 4);
        zeroize = 1'b1; key_load = 1'b1;
        tick();
        zeroize = 1'b0; key_load = 1'b0;
        check("zz_key", round_key, 0);
        check("zz_valid", rk_valid, 0);
        check("zz_busy", busy, 0);
        check("zz_idx", rk_index, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
